redun_mont_ctl: RTL

- Job controller and result reader at the far end of the redundant Montgomery squarer interface.
- Accepts a host job (initial value, iteration count T) and converts the value to redundant word form.
- Holds the squarer in reset, then releases it and issues the start strobe.
- Counts squarer completion strobes. On the T-th strobe it captures the redundant result, carry-propagates it word-serially to normal binary, and presents it on a valid/ready output.

---
 rtl/redun_mont_ctl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/redun_mont_ctl.sv
// Job controller for the redundant Montgomery squarer: loads and starts it, counts completions,
// then carry-propagates the redundant result to binary. Optional watchdog: REDUN_MONT_CTL_TIMEOUT_EN.
module redun_mont_ctl #(
  parameter int NUM_WRDS       = 64,
  parameter int WRD_BITS       = 16,
  parameter int REDUN_WRD_BITS = 17,
  parameter int ITER_BITS      = 40,
  parameter int RST_CYCLES     = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start,
  input  logic [NUM_WRDS*WRD_BITS-1:0]       i_init,
  input  logic [ITER_BITS-1:0]               i_iters,
  output logic                               o_busy,
  output logic                               o_sq_rst,
  output logic [NUM_WRDS*REDUN_WRD_BITS-1:0] o_sq,
  output logic                               o_sq_val,
  input  logic [NUM_WRDS*REDUN_WRD_BITS-1:0] i_mul,
  input  logic                               i_mul_val,
  output logic [ITER_BITS-1:0]               o_iter_cnt,
  output logic [NUM_WRDS*WRD_BITS-1:0]       o_res,
  output logic                               o_res_ovf,
  output logic                               o_res_val,
  input  logic                               i_res_rdy
`ifdef REDUN_MONT_CTL_TIMEOUT_EN
  ,
  output logic                               o_err
`endif
);

  localparam int RES_W   = NUM_WRDS * WRD_BITS;
  localparam int RED_W   = NUM_WRDS * REDUN_WRD_BITS;
  localparam int K_BITS  = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam int LD_BITS = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;

  localparam logic [K_BITS-1:0]  K_LAST = K_BITS'(NUM_WRDS - 1);
  localparam logic [LD_BITS-1:0] LD_REL = LD_BITS'(RST_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CONV,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [RED_W-1:0]     sq_q, sq_d;
  logic [ITER_BITS-1:0] iters_q, iters_d;
  logic [ITER_BITS-1:0] iter_cnt_q, iter_cnt_d;
  logic [LD_BITS-1:0]   ld_cnt_q, ld_cnt_d;
  logic [K_BITS-1:0]    k_q, k_d;
  logic [1:0]           carry_q, carry_d;
  logic [RES_W-1:0]     res_q, res_d;
  logic                 ovf_q, ovf_d;
  logic [RED_W-1:0]     buf_q, buf_d;
  logic [RED_W-1:0]     init_redun;
  logic [REDUN_WRD_BITS:0] sum;
  logic                 sq_rst;
  logic                 sq_val;

`ifdef REDUN_MONT_CTL_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
`endif

  // Each binary word becomes a redundant word with a clear spare bit.
  always_comb begin
    init_redun = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      init_redun[i*REDUN_WRD_BITS +: REDUN_WRD_BITS] =
        {{(REDUN_WRD_BITS-WRD_BITS){1'b0}}, i_init[i*WRD_BITS +: WRD_BITS]};
    end
  end

  // NOTE: every signal driven here gets its default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    sq_d       = sq_q;
    iters_d    = iters_q;
    iter_cnt_d = iter_cnt_q;
    ld_cnt_d   = ld_cnt_q;
    k_d        = k_q;
    carry_d    = carry_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    buf_d      = buf_q;
    sq_rst     = 1'b1;
    sq_val     = 1'b0;
`ifdef REDUN_MONT_CTL_TIMEOUT_EN
    wdog_d     = wdog_q;
    err_d      = 1'b0;
`endif
    sum = {1'b0, buf_q[REDUN_WRD_BITS-1:0]} + {{(REDUN_WRD_BITS-1){1'b0}}, carry_q};

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          sq_d       = init_redun;
          iters_d    = i_iters;
          iter_cnt_d = '0;
          ld_cnt_d   = '0;
          k_d        = '0;
          carry_d    = '0;
          if (i_iters == '0) begin
            buf_d   = init_redun;
            state_d = ST_CONV;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        sq_rst = (ld_cnt_q < LD_REL);
        if (ld_cnt_q == LD_REL) begin
          sq_val  = 1'b1;
          state_d = ST_RUN;
`ifdef REDUN_MONT_CTL_TIMEOUT_EN
          wdog_d  = 16'hFFFF;
`endif
        end else begin
          ld_cnt_d = ld_cnt_q + LD_BITS'(1);
        end
      end

      ST_RUN: begin
        sq_rst = 1'b0;
        if (i_mul_val) begin
          iter_cnt_d = iter_cnt_q + ITER_BITS'(1);
`ifdef REDUN_MONT_CTL_TIMEOUT_EN
          wdog_d     = 16'hFFFF;
`endif
          if (iter_cnt_d == iters_q) begin
            buf_d   = i_mul;
            carry_d = '0;
            k_d     = '0;
            state_d = ST_CONV;
          end
        end
`ifdef REDUN_MONT_CTL_TIMEOUT_EN
        else if (wdog_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q - 16'd1;
        end
`endif
      end

      // Word-serial carry propagation: the buffer shifts down and results shift in from the top,
      // so word 0 ends at the bottom of res_q after NUM_WRDS cycles.
      ST_CONV: begin
        buf_d   = buf_q >> REDUN_WRD_BITS;
        res_d   = {sum[WRD_BITS-1:0], res_q[RES_W-1:WRD_BITS]};
        carry_d = sum[WRD_BITS +: 2];
        if (k_q == K_LAST) begin
          ovf_d   = (sum[WRD_BITS +: 2] != 2'd0);
          state_d = ST_DONE;
        end else begin
          k_d = k_q + K_BITS'(1);
        end
      end

      ST_DONE: begin
        if (i_res_rdy) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      sq_q       <= '0;
      iters_q    <= '0;
      iter_cnt_q <= '0;
      ld_cnt_q   <= '0;
      k_q        <= '0;
      carry_q    <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sq_q       <= sq_d;
      iters_q    <= iters_d;
      iter_cnt_q <= iter_cnt_d;
      ld_cnt_q   <= ld_cnt_d;
      k_q        <= k_d;
      carry_q    <= carry_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: the working buffer has no reset; it is always loaded on CONV entry before it is read.
  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end

`ifdef REDUN_MONT_CTL_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wdog_q <= 16'hFFFF;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign o_err = err_q;
`endif

  assign o_busy     = (state_q != ST_IDLE);
  assign o_sq_rst   = sq_rst;
  assign o_sq_val   = sq_val;
  assign o_sq       = sq_q;
  assign o_iter_cnt = iter_cnt_q;
  assign o_res      = res_q;
  assign o_res_ovf  = ovf_q;
  assign o_res_val  = (state_q == ST_DONE);

endmodule
